// File: rtl/shift_add_mult4_pkg.sv
// Shared types and constants for the shift-add multiply unit.
// Imported by the control stage and the adder slice.
package shift_add_mult4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 2 * OP_W;

  localparam logic [1:0] LAST_ITER = 2'd3;

endpackage

// File: rtl/shift_add_mult4_rca4.sv
// Combinational 4-bit ripple-carry adder.
// Built from four full-adder slices chained on carry.
module rca4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i])
                    | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[4];

endmodule

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned shift-add multiplier.
// One operand pair per start; 8-bit product with a done pulse.
module shift_add_mult4
  import shift_add_mult4_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                busy,
  output logic                done,
  output logic [PROD_W-1:0]   product
);

  state_e              state_q;
  logic [OP_W-1:0]     m_q;
  logic [OP_W-1:0]     acc_q;
  logic [OP_W-1:0]     q_q;
  logic                c_q;
  logic [1:0]          cnt_q;
  logic [PROD_W-1:0]   prod_q;

  logic [OP_W-1:0]     sum;
  logic                cout;
  logic                c_d;
  logic [OP_W-1:0]     acc_d;
  logic [OP_W-1:0]     q_d;

  rca4 u_add (
    .a_i    (acc_q),
    .b_i    (m_q),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // 9-bit right shift of {C,A,Q}; adder carry lands in A[3]
  always_comb begin
    c_d   = 1'b0;
    acc_d = acc_q;
    q_d   = q_q;
    if (q_q[0]) begin
      {c_d, acc_d, q_d} = {1'b0, cout, sum, q_q[3:1]};
    end else begin
      {c_d, acc_d, q_d} = {1'b0, c_q, acc_q, q_q[3:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            m_q     <= a;
            q_q     <= b;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          c_q   <= c_d;
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == LAST_ITER) begin
            prod_q  <= {acc_d, q_d};
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mult4.sv
// Self-checking bench for shift_add_mult4.
// Reference product is plain integer multiplication.
module tb_shift_add_mult4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_mult4 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  function automatic logic [7:0] ref_mul(input logic [3:0] x,
                                         input logic [3:0] y);
    int p;
    p = int'(x) * int'(y);
    return p[7:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 4'hF; b = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (product !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got p=%h busy=%b done=%b want p=00 busy=0 done=0",
                 i, product, busy, done);
      end
    end
  endtask

  task automatic test_multiply(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] prev;
    logic [7:0] exp;
    exp  = ref_mul(x, y);
    @(negedge clk);
    prev = product;
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || product !== prev) begin
        errors++;
        $display("FAIL run_cycle %0dx%0d i=%0d got busy=%b done=%b p=%h want busy=1 done=0 p=%h",
                 x, y, i, busy, done, product, prev);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== exp) begin
      errors++;
      $display("FAIL done_cycle %0dx%0d got done=%b busy=%b p=%h want done=1 busy=0 p=%h",
               x, y, done, busy, product, exp);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== exp) begin
      errors++;
      $display("FAIL idle_hold %0dx%0d got done=%b busy=%b p=%h want done=0 busy=0 p=%h",
               x, y, done, busy, product, exp);
    end
  endtask

  task automatic test_directed();
    test_multiply(4'd15, 4'd15);
    test_multiply(4'd13, 4'd11);
    test_multiply(4'd0,  4'd9);
    test_multiply(4'd1,  4'd1);
    test_multiply(4'd9,  4'd0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      test_multiply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_ignore_restart();
    int ndone;
    logic [7:0] pdone;
    ndone = 0;
    pdone = 8'h00;
    @(negedge clk);
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd2; b = 4'd2; start = 1'b1;
    if (done) begin ndone++; pdone = product; end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin ndone++; pdone = product; end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL restart_done_count got %0d want 1", ndone);
    end
    checks++;
    if (pdone !== 8'h0F || product !== 8'h0F) begin
      errors++;
      $display("FAIL restart_product got done_p=%h p=%h want 0f", pdone, product);
    end
  endtask

  task automatic test_continuous_start();
    int gap;
    int ok;
    @(negedge clk);
    a = 4'd6; b = 4'd7; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      ok  = 0;
      while (gap < 20 && ok == 0) begin
        @(negedge clk);
        gap++;
        if (done === 1'b1) ok = 1;
      end
      checks++;
      if (ok == 0) begin
        errors++;
        $display("FAIL cont_timeout pulse=%0d no done within 20 cycles", k);
      end else if (gap != (k == 0 ? 5 : 6)) begin
        errors++;
        $display("FAIL cont_spacing pulse=%0d got %0d want %0d",
                 k, gap, (k == 0 ? 5 : 6));
      end
      checks++;
      if (product !== 8'h2A) begin
        errors++;
        $display("FAIL cont_product pulse=%0d got %h want 2a", k, product);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int ndone;
    ndone = 0;
    @(negedge clk);
    checks++;
    if (product !== 8'h2A) begin
      errors++;
      $display("FAIL abort_prior got %h want 2a", product);
    end
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b p=%h want 0 0 00",
               busy, done, product);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles want 0", ndone);
    end
    test_multiply(4'd4, 4'd3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_ignore_restart();
    test_random();
    test_continuous_start();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
